div_seq_unit: RTL and testbench

Multi-cycle radix-2 restoring integer divider that serves as the responder for the execute stage's divide request handshake. It accepts a one-cycle-sampled request (`in_valid`, `sign`, `srca`, `srcb`) and returns the MIPS DIV/DIVU result, quotient on `lo` and remainder on `hi`, with a single-cycle `out_valid`. It sits beside the execute-stage datapath. The hazard unit stalls the pipeline while `busy` is high or `out_valid` has not yet pulsed.

---
 rtl/div_seq_unit.sv | 131 +++++++++++++
 tb/tb_div_seq_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient on lo, remainder on hi, one-cycle out_valid pulse in DONE.
// Latency from accept to out_valid is WIDTH+2 cycles.
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             out_valid,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] a_orig;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;

  logic [WIDTH:0]        rem_sh;
  logic signed [WIDTH:0] diff;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1)
  // and is kept as an unsigned bit pattern.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                input logic             sgn);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    if (sgn && (sv < 0)) return $unsigned(-sv);
    return v;
  endfunction

  // Two's-complement negation applied only when the result sign is negative.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    if (neg) return $unsigned(-$signed(v));
    return v;
  endfunction

  assign accept = (state == S_IDLE) && in_valid && !cancel;

  // Shift in the next dividend bit and trial-subtract the divisor.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = $signed(rem_sh - {1'b0, dvsr});
  end

  // Control FSM: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (cancel) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_CALC;
            cnt   <= CNT_W'(WIDTH - 1);
          end
        end
        S_CALC: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_FIX:   state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture and per-cycle restoring step; qualified by the FSM so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q  <= sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
      neg_r  <= sign & srca[WIDTH-1];
      dz     <= (srcb == '0);
      a_orig <= srca;
      quo    <= abs_val(srca, sign);
      dvsr   <= abs_val(srcb, sign);
      rem    <= '0;
    end else if (state == S_CALC) begin
      rem <= (diff < 0) ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  // Result registers: sign correction (or divide-by-zero override) at FIX -> DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if ((state == S_FIX) && !cancel) begin
      if (dz) begin
        lo <= '1;
        hi <= a_orig;
      end else begin
        lo <= cond_neg(quo, neg_q);
        hi <= cond_neg(rem, neg_r);
      end
      div_by_zero <= dz;
    end
  end

  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC) || (state == S_FIX);

endmodule

// File: tb/tb_div_seq_unit.sv
// Testbench for div_seq_unit: directed and random divides checked against
// a plain-arithmetic reference, plus handshake, cancel and reset scenarios.
module tb_div_seq_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         sign;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         cancel;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_lo = '0;
  logic [W-1:0] last_hi = '0;
  logic         last_dz = 1'b0;

  div_seq_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sign        (sign),
    .srca        (srca),
    .srcb        (srcb),
    .cancel      (cancel),
    .out_valid   (out_valid),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS DIV/DIVU reference using native integer division.
  function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dzo);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; dzo = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      dzo = 1'b0;
    end else begin
      q = a / b; r = a % b; dzo = 1'b0;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; sign = 1'b0; srca = '0; srcb = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (hi !== '0) begin errors++; $display("FAIL reset hi got %h exp 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("FAIL reset lo got %h exp 0", lo); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset div_by_zero got %b exp 0", div_by_zero); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset idle busy got %b exp 0", busy); end
  endtask

  // One request accepted at T, cycle-exact checks of busy/out_valid and the result.
  task automatic test_op(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string nm);
    logic [W-1:0] eq, er;
    logic ed;
    model(sg, a, b, eq, er, ed);
    @(negedge clk);
    sign = sg; srca = a; srcb = b; in_valid = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == LAT)) begin
        errors++; $display("FAIL %s out_valid k=%0d got %b exp %b", nm, k, out_valid, (k == LAT));
      end
      checks++;
      if (busy !== (k <= LAT - 1)) begin
        errors++; $display("FAIL %s busy k=%0d got %b exp %b", nm, k, busy, (k <= LAT - 1));
      end
      if (k == LAT || k == LAT + 2) begin
        checks++; if (lo !== eq) begin errors++; $display("FAIL %s lo k=%0d got %h exp %h", nm, k, lo, eq); end
        checks++; if (hi !== er) begin errors++; $display("FAIL %s hi k=%0d got %h exp %h", nm, k, hi, er); end
        checks++; if (div_by_zero !== ed) begin errors++; $display("FAIL %s div_by_zero got %b exp %b", nm, div_by_zero, ed); end
      end
      if (k == 1) in_valid = 1'b0;
      srca = $urandom; srcb = $urandom; sign = 1'($urandom);
    end
    last_lo = eq; last_hi = er; last_dz = ed;
  endtask

  task automatic test_directed();
    test_op(1'b0, 32'd100,       32'd7,         "divu_100_7");
    test_op(1'b1, 32'hFFFFFFF9,  32'd2,         "div_m7_2");
    test_op(1'b1, 32'd7,         32'hFFFFFFFE,  "div_7_m2");
    test_op(1'b1, 32'h80000000,  32'hFFFFFFFF,  "div_overflow");
    test_op(1'b0, 32'h80000000,  32'hFFFFFFFF,  "divu_large");
    test_op(1'b0, 32'h12345678,  32'd0,         "divu_by_zero");
    test_op(1'b1, 32'h12345678,  32'd0,         "div_by_zero");
    test_op(1'b1, 32'h80000000,  32'd0,         "div_min_by_zero");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    bit sg;
    for (int i = 0; i < 24; i++) begin
      sg = 1'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 9));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFFFFFF;
      endcase
      test_op(sg, a, b, "random");
    end
  endtask

  // in_valid held high across DONE: second accept only in the following IDLE cycle.
  task automatic test_back_to_back();
    logic [W-1:0] q1, r1, q2, r2;
    logic d1, d2;
    logic [W-1:0] a2, b2;
    a2 = $urandom; b2 = $urandom_range(1, 1000);
    model(1'b1, 32'hFFFFFF00, 32'd10, q1, r1, d1);
    model(1'b0, a2, b2, q2, r2, d2);
    @(negedge clk);
    sign = 1'b1; srca = 32'hFFFFFF00; srcb = 32'd10; in_valid = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 34 || k == 69)) begin
        errors++; $display("FAIL b2b out_valid k=%0d got %b exp %b", k, out_valid, (k == 34 || k == 69));
      end
      checks++;
      if (busy !== ((k >= 1 && k <= 33) || (k >= 36 && k <= 68))) begin
        errors++; $display("FAIL b2b busy k=%0d got %b", k, busy);
      end
      if (k == 34 || k == 50) begin
        checks++; if (lo !== q1) begin errors++; $display("FAIL b2b lo1 k=%0d got %h exp %h", k, lo, q1); end
        checks++; if (hi !== r1) begin errors++; $display("FAIL b2b hi1 k=%0d got %h exp %h", k, hi, r1); end
      end
      if (k == 69) begin
        checks++; if (lo !== q2) begin errors++; $display("FAIL b2b lo2 got %h exp %h", lo, q2); end
        checks++; if (hi !== r2) begin errors++; $display("FAIL b2b hi2 got %h exp %h", hi, r2); end
      end
      if (k == 34) begin sign = 1'b0; srca = a2; srcb = b2; end
      if (k == 36) in_valid = 1'b0;
    end
    last_lo = q2; last_hi = r2; last_dz = d2;
  endtask

  // Cancel at T+10; cancel still high with in_valid at T+11 blocks the accept; accept at T+12.
  task automatic test_cancel();
    logic [W-1:0] q2, r2, a2, b2;
    logic d2;
    a2 = $urandom; b2 = -($urandom_range(2, 50));
    model(1'b1, a2, b2, q2, r2, d2);
    @(negedge clk);
    sign = 1'b0; srca = 32'd999; srcb = 32'd5; in_valid = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 46)) begin
        errors++; $display("FAIL cancel out_valid k=%0d got %b exp %b", k, out_valid, (k == 46));
      end
      checks++;
      if (busy !== ((k >= 1 && k <= 10) || (k >= 13 && k <= 45))) begin
        errors++; $display("FAIL cancel busy k=%0d got %b", k, busy);
      end
      if (k == 11 || k == 45) begin
        checks++; if (lo !== last_lo) begin errors++; $display("FAIL cancel lo held k=%0d got %h exp %h", k, lo, last_lo); end
        checks++; if (hi !== last_hi) begin errors++; $display("FAIL cancel hi held k=%0d got %h exp %h", k, hi, last_hi); end
      end
      if (k == 46) begin
        checks++; if (lo !== q2) begin errors++; $display("FAIL cancel lo new got %h exp %h", lo, q2); end
        checks++; if (hi !== r2) begin errors++; $display("FAIL cancel hi new got %h exp %h", hi, r2); end
      end
      if (k == 1)  in_valid = 1'b0;
      if (k == 10) cancel = 1'b1;
      if (k == 11) begin in_valid = 1'b1; sign = 1'b1; srca = a2; srcb = b2; end
      if (k == 12) cancel = 1'b0;
      if (k == 13) in_valid = 1'b0;
    end
    last_lo = q2; last_hi = r2; last_dz = d2;
  endtask

  // Cancel during FIX: no result written, no out_valid.
  task automatic test_cancel_fix();
    @(negedge clk);
    sign = 1'b0; srca = 32'd12345; srcb = 32'd11; in_valid = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL cancel_fix out_valid k=%0d got %b exp 0", k, out_valid); end
      checks++;
      if (busy !== (k <= 33)) begin errors++; $display("FAIL cancel_fix busy k=%0d got %b exp %b", k, busy, (k <= 33)); end
      if (k == 35) begin
        checks++; if (lo !== last_lo) begin errors++; $display("FAIL cancel_fix lo got %h exp %h", lo, last_lo); end
        checks++; if (hi !== last_hi) begin errors++; $display("FAIL cancel_fix hi got %h exp %h", hi, last_hi); end
      end
      if (k == 1)  in_valid = 1'b0;
      if (k == 33) cancel = 1'b1;
      if (k == 34) cancel = 1'b0;
    end
  endtask

  // Reset asserted mid-divide: outputs clear at once, no result afterwards.
  task automatic test_reset_mid();
    @(negedge clk);
    sign = 1'b1; srca = 32'hDEADBEEF; srcb = 32'd3; in_valid = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      if (k == 20) begin
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b exp 0", busy); end
        checks++; if (hi !== '0) begin errors++; $display("FAIL rst_mid hi got %h exp 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL rst_mid lo got %h exp 0", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rst_mid div_by_zero got %b exp 0", div_by_zero); end
      end
      if (k == 22) rst = 1'b1;
      if (k > 22) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL rst_mid after k=%0d out_valid %b busy %b exp 0 0", k, out_valid, busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_cancel_fix();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
